i2s_tx_ctrl: RTL
================

# i2s_tx_ctrl

I2S transmit sequencer that sits after the I2S clock generator. It receives the generator's bit clock (SCLK) and word-select (LRCLK) as level signals in the `i_clk` domain. It fetches one stereo sample pair per frame from an upstream source over a valid/ready handshake, and serializes the pair MSB-first onto `o_sdata` using the standard one-SCLK I2S data delay. It also covers the failure cases: underflow (zero-fill plus sticky flag), enable/disable sequencing, and frame counting.

## Interface
- DATA_W, 24, sample width in bits per channel (1..SLOT_W)
- SLOT_W, 32, SCLK periods per channel slot; sizes the bit counter
- i_clk  in  1  system clock, same clock as the I2S clock generator
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  transmit enable, level
- i_sclk  in  1  bit clock level, synchronous to i_clk
- i_lrclk  in  1  word select, synchronous to i_clk; 1 = left slot, 0 = right slot
- i_valid  in  1  upstream sample pair valid
- i_left  in  DATA_W  left sample
- i_right  in  DATA_W  right sample
- o_ready  out  1  fetch window open; a transfer occurs when i_valid and o_ready are both high
- o_sdata  out  1  serial data, registered
- o_active  out  1  high in RUN state
- o_underflow  out  1  sticky underflow flag
- i_clr_err  in  1  single-cycle pulse that clears o_underflow
- o_frame_cnt  out  16  count of frames loaded, wraps at 16'hFFFF→0

## Operation
- Edge detect: registers r_sclk_d and r_lrclk_d.
  - sclk_fall = r_sclk_d & ~i_sclk.
  - lr_rise = ~r_lrclk_d & i_lrclk.
  - lr_fall = r_lrclk_d & ~i_lrclk.
  - No synchronizers; the inputs are same-domain.
- FSM states: IDLE, SYNC, RUN.
  - IDLE → SYNC when i_en=1.
  - SYNC → RUN on lr_rise. Frames always start at a left slot.
  - Any state → IDLE when i_en=0, effective next cycle. In IDLE: o_sdata=0, o_ready=0, shift state cleared, any pending fetch window dropped.
- Fetch window:
  - Opens (o_ready=1) in the cycle lr_rise is detected in SYNC or RUN.
  - Closes on the first of: the handshake completing, or the first sclk_fall after lr_rise.
  - On handshake: latch i_left into the shift register and i_right into the hold register.
  - If the window closes without a handshake: load zeros into both, set o_underflow.
  - o_frame_cnt increments once per window close, whether loaded or underflowed.
- Shift:
  - lr_rise loads the left sample; lr_fall loads the right sample from the hold register. Either load resets bit_cnt=0 and clears the first-fall guard.
  - Each subsequent sclk_fall: o_sdata ← shift[DATA_W-1], shift left one bit, bit_cnt++.
  - For bit_cnt ≥ DATA_W, o_sdata=0 until the next LRCLK edge. bit_cnt saturates at SLOT_W.
- Simultaneous events:
  - LRCLK edge and sclk_fall in the same cycle: the LRCLK edge wins (load); that fall does not shift.
  - Handshake in the same cycle as the first sclk_fall: the handshake wins (data loaded); the MSB is driven on the following sclk_fall.
  - Window opening while the previous right slot is still shifting: the right slot keeps its hold data until lr_fall.
- Underflow flag: set has priority over i_clr_err in the same cycle.
- Reset: all registers are cleared.
  - Outputs o_sdata=0, o_ready=0, o_active=0, o_underflow=0, o_frame_cnt=0.
  - State = IDLE.
  - Reset mid-frame aborts immediately.

## Timing
- o_sdata changes 1 i_clk cycle after the first i_clk cycle in which i_sclk is sampled low following high.
- The MSB of each channel is driven on the first sclk_fall strictly after its LRCLK edge. This gives the one-SCLK I2S delay.
- o_ready rises 1 cycle after i_lrclk is sampled high following low. The data load is visible in the shift register 1 cycle after the handshake.
- o_active rises 1 cycle after the lr_rise that moves SYNC→RUN, and falls 1 cycle after i_en is sampled low.
- Throughput: 1 pair per LRCLK period. Upstream must answer within the window, which is roughly half an SCLK period after lr_rise.

## Test plan
- Reset: hold i_rst_n=0 with random inputs → all outputs 0. Release and keep i_en=0 → o_sdata stays 0 and o_ready stays 0.
- Nominal frame: SCLK period 48 cycles, LRCLK period 3072 cycles, i_valid=1, left=24'hA5A5A5, right=24'h3C3C3C.
  - Left slot: 24 bits A5A5A5 MSB-first starting on the first fall after lr_rise, then 8 zeros.
  - Right slot: 3C3C3C in the same pattern.
  - o_frame_cnt=1.
- Underflow: i_valid=0 throughout the window → 64 zero bits. o_underflow=1, o_frame_cnt increments.
  - A later i_clr_err pulse → o_underflow=0.
  - i_clr_err coincident with a new underflow → o_underflow stays 1.
- Late valid: i_valid rises 30 cycles after the window closes → no transfer and o_ready=0 at that point. The frame is zero-filled; the next frame loads the held pair.
- Enable while i_lrclk=0 → SYNC, no output until lr_rise. Deassert i_en mid-left-slot → o_sdata=0 next cycle and o_active=0. Re-enable → waits for the next lr_rise.
- Coincident edges: force an lr_rise in the same cycle as an sclk_fall → no shift in that cycle, and the MSB appears on the next fall.

Source files
------------

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: fetches one stereo pair per LRCLK frame and
// serializes it MSB-first with the one-SCLK I2S delay.
module i2s_tx_ctrl #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_sclk,
    input  logic              i_lrclk,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_ready,
    output logic              o_sdata,
    output logic              o_active,
    output logic              o_underflow,
    input  logic              i_clr_err,
    output logic [15:0]       o_frame_cnt
);

    localparam int CW = $clog2(SLOT_W + 1);
    localparam logic [CW-1:0] DW_C = CW'(DATA_W);
    localparam logic [CW-1:0] SW_C = CW'(SLOT_W);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t            state_q, state_d;
    logic              sclk_q, lrclk_q;
    logic              win_q, win_d;
    logic              sdata_q, sdata_d;
    logic              uf_q, uf_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [CW-1:0]     bit_q, bit_d;

    logic sclk_fall, lr_rise, lr_fall, hs;

    assign sclk_fall = sclk_q & ~i_sclk;
    assign lr_rise   = ~lrclk_q & i_lrclk;
    assign lr_fall   = lrclk_q & ~i_lrclk;
    assign hs        = win_q & i_valid;

    assign o_ready     = win_q;
    assign o_sdata     = sdata_q;
    assign o_active    = (state_q == RUN);
    assign o_underflow = uf_q;
    assign o_frame_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sdata_d = sdata_q;
        uf_d    = uf_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        if (i_clr_err) uf_d = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
            win_d   = 1'b0;
            sdata_d = 1'b0;
            shift_d = '0;
            hold_d  = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    if (lr_rise) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
            // LRCLK edges outrank any coincident SCLK fall.
            if (state_q != IDLE) begin
                if (lr_rise) begin
                    win_d   = 1'b1;
                    shift_d = '0;
                    bit_d   = '0;
                end else if (lr_fall && state_q == RUN) begin
                    shift_d = hold_q;
                    bit_d   = '0;
                end else if (win_q) begin
                    if (hs) begin
                        shift_d = i_left;
                        hold_d  = i_right;
                        win_d   = 1'b0;
                        cnt_d   = cnt_q + 16'd1;
                    end else if (sclk_fall) begin
                        shift_d = '0;
                        hold_d  = '0;
                        win_d   = 1'b0;
                        cnt_d   = cnt_q + 16'd1;
                        uf_d    = 1'b1;
                    end
                end else if (sclk_fall && state_q == RUN) begin
                    if (bit_q < DW_C) begin
                        sdata_d = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end else begin
                        sdata_d = 1'b0;
                    end
                    if (bit_q < SW_C) bit_d = bit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            win_q   <= 1'b0;
            sdata_q <= 1'b0;
            uf_q    <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= i_sclk;
            lrclk_q <= i_lrclk;
            win_q   <= win_d;
            sdata_q <= sdata_d;
            uf_q    <= uf_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
        end
    end

endmodule
